bimodal_branch_predictor: RTL and testbench

- Dynamic successor to the static backward-taken predictor for the dual-slot, 64-bit fetch front end.
- Keeps a banked table of saturating counters indexed by instruction address and predicts per slot. Slot 0 is the low word at delayed_pc; slot 1 is the high word at delayed_pc+4.
- Trained by the execute stage. Sits between the fetch address register and the fetch/decode boundary, with one-cycle read latency aligned to instruction return.

---
 rtl/bimodal_branch_predictor.sv | 192 +++++++++++++++++++
 tb/tb_bimodal_branch_predictor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bimodal_branch_predictor.sv
// Bimodal branch predictor for a dual-slot 64-bit fetch front end: banked saturating
// counters with a static backward-taken fallback while the table sweeps. Optional stats via BP_STATS_EN.
module bimodal_branch_predictor #(
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_valid,
  input  logic [31:0]         fetch_pc,
  input  logic [31:0]         instruction_low,
  input  logic [31:0]         instruction_high,
  input  logic [31:0]         delayed_pc,
  input  logic                delayed_pc2,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [CTR_BITS-1:0] upd_ctr,
  output logic                take_branch,
  output logic [31:0]         target,
  output logic                instrBSkipped,
  output logic [CTR_BITS-1:0] pred_ctr0,
  output logic [CTR_BITS-1:0] pred_ctr1,
  output logic                init_done
`ifdef BP_STATS_EN
  ,
  input  logic                upd_mispredict,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int BANK_N = BHT_ENTRIES / 2;
  localparam int IDX_W  = $clog2(BANK_N);
  localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [6:0]          OPC_BR   = 7'b1100011;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    init_idx_q, init_idx_d;
  logic                init_done_q, init_done_d;
  logic [CTR_BITS-1:0] rd0_q, rd0_d, rd1_q, rd1_d;

  logic [CTR_BITS-1:0] bank0_mem [BANK_N];
  logic [CTR_BITS-1:0] bank1_mem [BANK_N];

  logic                wr_en0, wr_en1;
  logic [IDX_W-1:0]    wr_idx;
  logic [CTR_BITS-1:0] wr_data;
  logic [CTR_BITS-1:0] upd_new;
  logic [IDX_W-1:0]    rd_idx;

  assign rd_idx = fetch_pc[IDX_W+2:3];

  always_comb begin
    if (upd_taken) upd_new = (upd_ctr == CTR_MAX) ? upd_ctr : upd_ctr + CTR_BITS'(1);
    else           upd_new = (upd_ctr == '0)      ? upd_ctr : upd_ctr - CTR_BITS'(1);
  end

  // Single write port per bank, shared between the init sweep and execute-stage training.
  always_comb begin
    wr_en0  = 1'b0;
    wr_en1  = 1'b0;
    wr_idx  = '0;
    wr_data = INIT_VAL;
    if (state_q == S_INIT) begin
      wr_en0  = 1'b1;
      wr_en1  = 1'b1;
      wr_idx  = init_idx_q;
    end else if (upd_valid) begin
      wr_en0  = ~upd_pc[2];
      wr_en1  = upd_pc[2];
      wr_idx  = upd_pc[IDX_W+2:3];
      wr_data = upd_new;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en0) bank0_mem[wr_idx] <= wr_data;
    if (wr_en1) bank1_mem[wr_idx] <= wr_data;
  end

  // Read registers hold on stall; same-cycle writes to the read index are forwarded.
  always_comb begin
    rd0_d = rd0_q;
    rd1_d = rd1_q;
    if (fetch_valid) begin
      if (state_q == S_INIT) begin
        rd0_d = INIT_VAL;
        rd1_d = INIT_VAL;
      end else begin
        rd0_d = (wr_en0 && (wr_idx == rd_idx)) ? wr_data : bank0_mem[rd_idx];
        rd1_d = (wr_en1 && (wr_idx == rd_idx)) ? wr_data : bank1_mem[rd_idx];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = (state_q == S_RUN);
    if (state_q == S_INIT) begin
      init_idx_d = init_idx_q + IDX_W'(1);
      if (init_idx_q == IDX_W'(BANK_N - 1)) state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      rd0_q       <= '0;
      rd1_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      rd0_q       <= rd0_d;
      rd1_q       <= rd1_d;
    end
  end

  logic        br0, br1, p0, p1;
  logic [31:0] imm0, imm1;

  assign br0  = (instruction_low[6:0]  == OPC_BR);
  assign br1  = (instruction_high[6:0] == OPC_BR);
  assign imm0 = {{20{instruction_low[31]}}, instruction_low[7], instruction_low[30:25],
                 instruction_low[11:8], 1'b0};
  assign imm1 = {{20{instruction_high[31]}}, instruction_high[7], instruction_high[30:25],
                 instruction_high[11:8], 1'b0};
  assign p0   = br0 && ((state_q == S_RUN) ? rd0_q[CTR_BITS-1] : instruction_low[31]);
  assign p1   = br1 && ((state_q == S_RUN) ? rd1_q[CTR_BITS-1] : instruction_high[31]);

  always_comb begin
    take_branch   = 1'b0;
    target        = '0;
    instrBSkipped = 1'b0;
    if (delayed_pc2) begin
      if (p1) begin
        take_branch = 1'b1;
        target      = delayed_pc + 32'd4 + imm1;
      end
    end else if (p0) begin
      take_branch   = 1'b1;
      target        = delayed_pc + imm0;
      instrBSkipped = 1'b1;
    end else if (p1) begin
      take_branch = 1'b1;
      target      = delayed_pc + 32'd4 + imm1;
    end
  end

  assign pred_ctr0 = rd0_q;
  assign pred_ctr1 = rd1_q;
  assign init_done = init_done_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if ((state_q == S_RUN) && upd_valid) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (upd_mispredict) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{fetch_pc[31:IDX_W+3], fetch_pc[2:0], upd_pc[31:IDX_W+3], upd_pc[1:0],
                         instruction_low[24:12], instruction_high[24:12]};

endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// Directed bench for bimodal_branch_predictor: expected fetch results are queued at
// launch and popped when the bundle returns a cycle later.
module tb_bimodal_branch_predictor;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] instruction_low, instruction_high, delayed_pc;
  logic        delayed_pc2;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [1:0]  upd_ctr;
  logic        upd_mispredict;
  logic        take_branch, instrBSkipped, init_done;
  logic [31:0] target;
  logic [1:0]  pred_ctr0, pred_ctr1;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic        take;
    logic [31:0] tgt;
    logic        skip;
    logic [1:0]  c0;
    logic [1:0]  c1;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bimodal_branch_predictor #(.BHT_ENTRIES(64), .CTR_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .instruction_low(instruction_low), .instruction_high(instruction_high),
    .delayed_pc(delayed_pc), .delayed_pc2(delayed_pc2),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ctr(upd_ctr),
    .take_branch(take_branch), .target(target), .instrBSkipped(instrBSkipped),
    .pred_ctr0(pred_ctr0), .pred_ctr1(pred_ctr1), .init_done(init_done)
`ifdef BP_STATS_EN
    , .upd_mispredict(upd_mispredict), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  function automatic logic [31:0] benc(input int imm);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], 5'd0, 5'd0, 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] lo, input logic [31:0] hi,
                       input string tag, input logic tk, input logic [31:0] tg,
                       input logic sk, input logic [1:0] c0, input logic [1:0] c1);
    exp_t e;
    e.tag = tag; e.take = tk; e.tgt = tg; e.skip = sk; e.c0 = c0; e.c1 = c1;
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    fetch_valid      = 1'b0;
    upd_valid        = 1'b0;
    instruction_low  = lo;
    instruction_high = hi;
    delayed_pc       = {pc[31:3], 3'b000};
    delayed_pc2      = pc[2];
    #1;
    e = sb.pop_front();
    chk({e.tag, ".take"},   {31'd0, take_branch},   {31'd0, e.take});
    chk({e.tag, ".target"}, target,                 e.tgt);
    chk({e.tag, ".skip"},   {31'd0, instrBSkipped}, {31'd0, e.skip});
    chk({e.tag, ".ctr0"},   {30'd0, pred_ctr0},     {30'd0, e.c0});
    chk({e.tag, ".ctr1"},   {30'd0, pred_ctr1},     {30'd0, e.c1});
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [1:0] ctr,
                        input logic mis);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_ctr        = ctr;
    upd_mispredict = mis;
    @(posedge clk);
    @(negedge clk);
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
    instruction_low = '0; instruction_high = '0; delayed_pc = '0; delayed_pc2 = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_ctr = '0; upd_mispredict = 1'b0;
    #2;
    chk("rst.init_done", {31'd0, init_done},     32'd0);
    chk("rst.ctr0",      {30'd0, pred_ctr0},     32'd0);
    chk("rst.ctr1",      {30'd0, pred_ctr1},     32'd0);
    chk("rst.take",      {31'd0, take_branch},   32'd0);
    chk("rst.target",    target,                 32'd0);
    chk("rst.skip",      {31'd0, instrBSkipped}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    // Static fallback while sweeping; this fetch consumes the first post-reset edge.
    fetch(32'h100, benc(-16), NOP, "init_static", 1'b1, 32'hF0, 1'b1, 2'd1, 2'd1);
    repeat (31) @(posedge clk);
    @(negedge clk);
    chk("init_done@32", {31'd0, init_done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("init_done@33", {31'd0, init_done}, 32'd1);

    fetch(32'h200, benc(16), NOP, "fwd_weak", 1'b0, 32'h0, 1'b0, 2'd1, 2'd1);
    update(32'h200, 1'b1, 2'd1, 1'b0);
    update(32'h200, 1'b1, 2'd2, 1'b0);
    fetch(32'h200, benc(16), NOP, "fwd_trained", 1'b1, 32'h210, 1'b1, 2'd3, 2'd1);

    update(32'h200, 1'b1, 2'd3, 1'b0);
    fetch(32'h200, NOP, NOP, "sat_hi", 1'b0, 32'h0, 1'b0, 2'd3, 2'd1);
    update(32'h208, 1'b0, 2'd0, 1'b0);
    fetch(32'h208, NOP, NOP, "sat_lo", 1'b0, 32'h0, 1'b0, 2'd0, 2'd1);

    // 0x300/0x304 alias index 0 of both banks (bank0 already trained to 3).
    update(32'h304, 1'b1, 2'd2, 1'b0);
    fetch(32'h300, NOP, benc(-8), "slot1", 1'b1, 32'h2FC, 1'b0, 2'd3, 2'd3);
    fetch(32'h304, benc(16), benc(-8), "dpc2_s1", 1'b1, 32'h2FC, 1'b0, 2'd3, 2'd3);
    fetch(32'h304, benc(16), NOP, "dpc2_s0_ign", 1'b0, 32'h0, 1'b0, 2'd3, 2'd3);

    upd_valid = 1'b1; upd_pc = 32'h404; upd_taken = 1'b0; upd_ctr = 2'd3;
    fetch(32'h400, NOP, NOP, "wr_fwd", 1'b0, 32'h0, 1'b0, 2'd3, 2'd2);
    update(32'h404, 1'b0, 2'd2, 1'b0);
    repeat (2) @(negedge clk);
    chk("stall.ctr0", {30'd0, pred_ctr0}, 32'd3);
    chk("stall.ctr1", {30'd0, pred_ctr1}, 32'd2);
    fetch(32'h400, NOP, NOP, "after_stall", 1'b0, 32'h0, 1'b0, 2'd3, 2'd1);

    @(negedge clk);
    rst_n = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1; upd_ctr = 2'd2;
    #1;
    chk("midrst.init_done", {31'd0, init_done}, 32'd0);
    chk("midrst.ctr0",      {30'd0, pred_ctr0}, 32'd0);
    chk("midrst.ctr1",      {30'd0, pred_ctr1}, 32'd0);
    @(negedge clk);
    upd_valid = 1'b0;
    rst_n = 1'b1;
    update(32'h200, 1'b1, 2'd2, 1'b1);
    repeat (32) @(posedge clk);
    @(negedge clk);
    chk("reinit_done", {31'd0, init_done}, 32'd1);
    fetch(32'h200, NOP, NOP, "reinit_a", 1'b0, 32'h0, 1'b0, 2'd1, 2'd1);
    fetch(32'h400, NOP, NOP, "reinit_b", 1'b0, 32'h0, 1'b0, 2'd1, 2'd1);
    fetch(32'h208, NOP, NOP, "reinit_c", 1'b0, 32'h0, 1'b0, 2'd1, 2'd1);

`ifdef BP_STATS_EN
    chk("stat.br0",  stat_branches,    32'd0);
    chk("stat.mis0", stat_mispredicts, 32'd0);
    update(32'h200, 1'b1, 2'd1, 1'b1);
    update(32'h208, 1'b0, 2'd1, 1'b0);
    update(32'h210, 1'b1, 2'd1, 1'b1);
    update(32'h218, 1'b0, 2'd1, 1'b0);
    update(32'h220, 1'b1, 2'd1, 1'b0);
    chk("stat.br5",  stat_branches,    32'd5);
    chk("stat.mis2", stat_mispredicts, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
